// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory data register and its lane aligner.
// Size codes follow the access-size encoding driven by the control unit.
package mdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // Byte-lane mask for an access at offset 0; callers shift it into position.
  function automatic logic [7:0] be_base_mask(input logic [1:0] sz);
    logic [7:0] m;
    unique case (sz)
      SZ_BYTE:  m = 8'h01;
      SZ_HALF:  m = 8'h03;
      SZ_WORD:  m = 8'h0F;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational byte-lane steering for sub-word loads and stores, plus
// alignment legality of the requested access.
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter int unsigned REG_SIZE = 32,
  localparam int unsigned LANES = REG_SIZE / 8,
  localparam int unsigned LSB_W = $clog2(LANES)
) (
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [LSB_W-1:0]    addr_lsb,
  input  logic [REG_SIZE-1:0] rd_data,
  input  logic [REG_SIZE-1:0] mdr_data,
  output logic [REG_SIZE-1:0] ld_data,
  output logic [REG_SIZE-1:0] st_data,
  output logic [LANES-1:0]    st_byte_en,
  output logic                illegal
);

  logic [LANES-1:0]    lane_mask;
  logic [REG_SIZE-1:0] bit_mask;
  logic [REG_SIZE-1:0] ld_shift;
  logic [LSB_W+2:0]    bit_off;
  logic                ext_bit;

  always_comb begin
    lane_mask = LANES'(be_base_mask(size));
    bit_mask  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    bit_off  = {addr_lsb, 3'b000};
    ld_shift = rd_data >> bit_off;

    // A full-width access has nothing above it to extend into.
    unique case (size)
      SZ_BYTE: ext_bit = ld_shift[7];
      SZ_HALF: ext_bit = ld_shift[15];
      SZ_WORD: ext_bit = (REG_SIZE > 32) ? ld_shift[31] : 1'b0;
      default: ext_bit = 1'b0;
    endcase

    ld_data    = (ld_shift & bit_mask) | ((sign_ext && ext_bit) ? ~bit_mask : '0);
    st_data    = (mdr_data & bit_mask) << bit_off;
    st_byte_en = lane_mask << addr_lsb;

    unique case (size)
      SZ_HALF:  illegal = addr_lsb[0];
      SZ_WORD:  illegal = |addr_lsb[1:0];
      SZ_DWORD: illegal = (REG_SIZE == 32) || (|addr_lsb);
      default:  illegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with a request/ready handshake to variable-latency
// memory, sub-word alignment and a bounded wait for completion.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int unsigned REG_SIZE       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned LANES = REG_SIZE / 8,
  localparam int unsigned LSB_W = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mdr_in,
  input  logic [REG_SIZE-1:0] bus_mux_out,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [LSB_W-1:0]    addr_lsb,
  input  logic [REG_SIZE-1:0] m_data_in,
  input  logic                m_ready,
  output logic                m_req,
  output logic                m_we,
  output logic [LANES-1:0]    m_byte_en,
  output logic [REG_SIZE-1:0] m_data_out,
  output logic [REG_SIZE-1:0] mdr_output,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [REG_SIZE-1:0] mdr_q, mdr_d;
  logic [REG_SIZE-1:0] dout_d;
  logic                req_d, we_d;
  logic [LANES-1:0]    be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          lat_size_q, lat_size_d;
  logic                lat_sext_q, lat_sext_d;
  logic [LSB_W-1:0]    lat_lsb_q, lat_lsb_d;

  logic [1:0]          al_size;
  logic                al_sext;
  logic [LSB_W-1:0]    al_lsb;
  logic [REG_SIZE-1:0] ld_data, st_data;
  logic [LANES-1:0]    st_byte_en;
  logic                illegal;

  // One aligner serves both paths: live inputs decide the command in IDLE,
  // the latched access shapes the returning read data afterwards.
  assign al_size = (state_q == ST_IDLE) ? size     : lat_size_q;
  assign al_sext = (state_q == ST_IDLE) ? sign_ext : lat_sext_q;
  assign al_lsb  = (state_q == ST_IDLE) ? addr_lsb : lat_lsb_q;

  mdr_lane_align #(.REG_SIZE(REG_SIZE)) u_align (
    .size       (al_size),
    .sign_ext   (al_sext),
    .addr_lsb   (al_lsb),
    .rd_data    (m_data_in),
    .mdr_data   (mdr_q),
    .ld_data    (ld_data),
    .st_data    (st_data),
    .st_byte_en (st_byte_en),
    .illegal    (illegal)
  );

  always_comb begin
    state_d    = state_q;
    mdr_d      = mdr_q;
    req_d      = m_req;
    we_d       = m_we;
    be_d       = m_byte_en;
    dout_d     = m_data_out;
    cnt_d      = cnt_q;
    err_d      = err_q;
    lat_size_d = lat_size_q;
    lat_sext_d = lat_sext_q;
    lat_lsb_d  = lat_lsb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read && mem_write) begin
          state_d = ST_FINISH;
          err_d   = 1'b1;
        end else if ((mem_read || mem_write) && illegal) begin
          state_d = ST_FINISH;
          err_d   = 1'b1;
        end else if (mem_read) begin
          lat_size_d = size;
          lat_sext_d = sign_ext;
          lat_lsb_d  = addr_lsb;
          req_d      = 1'b1;
          we_d       = 1'b0;
          be_d       = st_byte_en;
          cnt_d      = '0;
          state_d    = ST_RD_WAIT;
        end else if (mem_write) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          be_d    = st_byte_en;
          dout_d  = st_data;
          cnt_d   = '0;
          state_d = ST_WR_WAIT;
        end else if (mdr_in) begin
          mdr_d = bus_mux_out;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // Comparing against TIMEOUT_CYCLES-1 before incrementing gives
        // exactly TIMEOUT_CYCLES request cycles.
        if (m_ready) begin
          if (state_q == ST_RD_WAIT) mdr_d = ld_data;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mdr_q      <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_byte_en  <= '0;
      m_data_out <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      lat_size_q <= SZ_BYTE;
      lat_sext_q <= 1'b0;
      lat_lsb_q  <= '0;
    end else begin
      state_q    <= state_d;
      mdr_q      <= mdr_d;
      m_req      <= req_d;
      m_we       <= we_d;
      m_byte_en  <= be_d;
      m_data_out <= dout_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      lat_size_q <= lat_size_d;
      lat_sext_q <= lat_sext_d;
      lat_lsb_q  <= lat_lsb_d;
    end
  end

  assign mdr_output = mdr_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign error      = done && err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Bench for mdr_mem_port: a 32-bit and a 64-bit instance share stimulus,
// and a byte-arithmetic reference model predicts every result.
module tb_mdr_mem_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel64 = 1'b0;
  logic        mdr_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0, sext = 1'b0, m_ready = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [2:0]  lsb = 3'd0;
  logic [63:0] bus = '0, mdata = '0;

  logic        req32, we32, busy32, done32, err32;
  logic [3:0]  be32;
  logic [31:0] dout32, mdr32;
  logic        req64, we64, busy64, done64, err64;
  logic [7:0]  be64;
  logic [63:0] dout64, mdr64;

  logic        o_req, o_we, o_busy, o_done, o_err;
  logic [7:0]  o_be;
  logic [63:0] o_dout, o_mdr;

  int errors = 0;
  int checks = 0;

  int          obs_req, obs_done_at;
  logic        obs_err, obs_stable, obs_we;
  logic [7:0]  obs_be;
  logic [63:0] obs_dout, obs_mdr;
  logic [1:0]  obs_after;

  always #5 clk = ~clk;

  mdr_mem_port #(.REG_SIZE(32), .TIMEOUT_CYCLES(15)) dut32 (
    .clk(clk), .reset_n(reset_n), .mdr_in(mdr_in & ~sel64), .bus_mux_out(bus[31:0]),
    .mem_read(mem_read & ~sel64), .mem_write(mem_write & ~sel64), .size(sz),
    .sign_ext(sext), .addr_lsb(lsb[1:0]), .m_data_in(mdata[31:0]),
    .m_ready(m_ready & ~sel64), .m_req(req32), .m_we(we32), .m_byte_en(be32),
    .m_data_out(dout32), .mdr_output(mdr32), .busy(busy32), .done(done32), .error(err32)
  );

  mdr_mem_port #(.REG_SIZE(64), .TIMEOUT_CYCLES(15)) dut64 (
    .clk(clk), .reset_n(reset_n), .mdr_in(mdr_in & sel64), .bus_mux_out(bus),
    .mem_read(mem_read & sel64), .mem_write(mem_write & sel64), .size(sz),
    .sign_ext(sext), .addr_lsb(lsb), .m_data_in(mdata),
    .m_ready(m_ready & sel64), .m_req(req64), .m_we(we64), .m_byte_en(be64),
    .m_data_out(dout64), .mdr_output(mdr64), .busy(busy64), .done(done64), .error(err64)
  );

  assign o_req  = sel64 ? req64  : req32;
  assign o_we   = sel64 ? we64   : we32;
  assign o_busy = sel64 ? busy64 : busy32;
  assign o_done = sel64 ? done64 : done32;
  assign o_err  = sel64 ? err64  : err32;
  assign o_be   = sel64 ? be64   : {4'b0, be32};
  assign o_dout = sel64 ? dout64 : {32'b0, dout32};
  assign o_mdr  = sel64 ? mdr64  : {32'b0, mdr32};

  // ---------------- reference model ----------------
  function automatic logic [63:0] size_mask(input logic [1:0] s);
    int nb = 1 << s;
    return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [1:0] s,
                                           input logic sx, input int l, input int w);
    logic [63:0] m = size_mask(s);
    int nb = 1 << s;
    logic [63:0] v = ((d & wmask(w)) >> (8 * l)) & m;
    if (sx && (8 * nb < w) && v[8*nb-1]) v = v | ~m;
    return v & wmask(w);
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] mdr, input logic [1:0] s,
                                            input int l, input int w);
    return ((mdr & size_mask(s)) << (8 * l)) & wmask(w);
  endfunction

  function automatic logic [7:0] ref_be(input logic [1:0] s, input int l);
    int nb = 1 << s;
    return 8'(((1 << nb) - 1) << l);
  endfunction

  function automatic bit ref_legal(input logic [1:0] s, input int l, input int w);
    if (s == 2'b11 && w == 32) return 1'b0;
    return (l % (1 << s)) == 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic bus_load(input logic [63:0] v);
    bus = v; mdr_in = 1'b1;
    @(posedge clk); #1;
    mdr_in = 1'b0;
  endtask

  // Issues one command and records what the port did; r<0 never answers.
  task automatic run_cmd(input bit rd, input bit wr, input logic [1:0] s, input bit sx,
                         input int l, input logic [63:0] md, input int r, input bit noise);
    mem_read = rd; mem_write = wr; sz = s; sext = sx; lsb = 3'(l); mdata = md; m_ready = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    obs_req = 0; obs_done_at = -1; obs_stable = 1'b1; obs_err = 1'b0;
    obs_we = 1'b0; obs_be = '0; obs_dout = '0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) begin obs_done_at = c; obs_err = o_err; break; end
      if (o_req) begin
        if (obs_req == 0) begin obs_we = o_we; obs_be = o_be; obs_dout = o_dout; end
        else if ({o_we, o_be, o_dout} !== {obs_we, obs_be, obs_dout}) obs_stable = 1'b0;
        m_ready = (r >= 0 && obs_req == r);
        obs_req++;
      end else begin
        m_ready = 1'b0;
      end
      if (noise) begin mdr_in = 1'b1; mem_read = 1'b1; bus = ~md; end
      @(posedge clk); #1;
    end
    m_ready = 1'b0; mdr_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    obs_mdr = o_mdr;
    @(posedge clk); #1;
    obs_after = {o_done, o_busy};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    sel64 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req32, we32, be32, dout32, mdr32, busy32, done32, err32} !== '0) begin
      errors++; $display("FAIL reset_values32 got %h exp 0", {req32, we32, be32, dout32, mdr32, busy32, done32, err32});
    end
    bus_load(64'h5A5A_5A5A);
    mem_read = 1'b1; sz = 2'b10; lsb = 3'd0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL reset_pre_req got %b exp 1", o_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({req32, we32, be32, dout32, mdr32, busy32, done32, err32} !== '0) begin
      errors++; $display("FAIL reset_async32 got %h exp 0", {req32, we32, be32, dout32, mdr32, busy32, done32, err32});
    end
    checks++;
    if ({req64, we64, be64, dout64, mdr64, busy64, done64, err64} !== '0) begin
      errors++; $display("FAIL reset_async64 got %h exp 0", {req64, we64, be64, dout64, mdr64, busy64, done64, err64});
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_busy, o_req, o_mdr} !== '0) begin errors++; $display("FAIL reset_release got %h exp 0", {o_busy, o_req, o_mdr}); end
  endtask

  task automatic test_bus_load;
    sel64 = 1'b0;
    bus_load(64'hDEAD_BEEF);
    checks++;
    if (o_mdr !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bus_load32 got %h exp deadbeef", o_mdr); end
    bus = 64'h1111_2222; mdr_in = 1'b1;
    run_cmd(1, 0, 2'b10, 0, 0, 64'hCAFE_F00D, 0, 0);
    checks++;
    if (obs_mdr !== 64'hCAFE_F00D) begin errors++; $display("FAIL cmd_beats_mdr_in got %h exp cafef00d", obs_mdr); end
    sel64 = 1'b1;
    bus_load(64'h0123_4567_89AB_CDEF);
    checks++;
    if (o_mdr !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL bus_load64 got %h exp 0123456789abcdef", o_mdr); end
  endtask

  task automatic test_signed_byte;
    sel64 = 1'b0;
    run_cmd(1, 0, 2'b00, 1, 2, 64'h1280_3456, 3, 1);
    checks++;
    if (obs_mdr !== 64'hFFFF_FF80) begin errors++; $display("FAIL sbyte_mdr got %h exp ffffff80", obs_mdr); end
    checks++;
    if (obs_done_at !== 4 || obs_req !== 4) begin
      errors++; $display("FAIL sbyte_latency got done_at=%0d req=%0d exp 4/4", obs_done_at, obs_req);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_after !== 2'b00) begin
      errors++; $display("FAIL sbyte_done_pulse got err=%b after=%b exp 0/00", obs_err, obs_after);
    end
  endtask

  task automatic test_half_store;
    sel64 = 1'b0;
    bus_load(64'h0000_ABCD);
    run_cmd(0, 1, 2'b01, 0, 2, 64'h0, 2, 0);
    checks++;
    if ({obs_we, obs_be, obs_dout} !== {1'b1, 8'b0000_1100, 64'hABCD_0000}) begin
      errors++; $display("FAIL hstore_bus got we=%b be=%b data=%h exp 1/1100/abcd0000", obs_we, obs_be, obs_dout);
    end
    checks++;
    if (obs_stable !== 1'b1 || obs_req !== 3 || obs_err !== 1'b0) begin
      errors++; $display("FAIL hstore_window got stable=%b req=%0d err=%b exp 1/3/0", obs_stable, obs_req, obs_err);
    end
    checks++;
    if (obs_mdr !== 64'hABCD) begin errors++; $display("FAIL hstore_mdr got %h exp abcd", obs_mdr); end
  endtask

  task automatic test_timeout;
    sel64 = 1'b0;
    bus_load(64'h1357_9BDF);
    run_cmd(1, 0, 2'b10, 0, 0, 64'hFFFF_FFFF, -1, 0);
    checks++;
    if (obs_req !== 15 || obs_done_at !== 15) begin
      errors++; $display("FAIL timeout_len got req=%0d done_at=%0d exp 15/15", obs_req, obs_done_at);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_mdr !== 64'h1357_9BDF) begin
      errors++; $display("FAIL timeout_result got err=%b mdr=%h exp 1/13579bdf", obs_err, obs_mdr);
    end
  endtask

  task automatic test_illegal;
    logic [3:0] rd_v, wr_v, sel_v;
    logic [7:0] sz_v;
    logic [11:0] lsb_v;
    rd_v = 4'b1111; wr_v = 4'b0110; sel_v = 4'b1000;
    sz_v = 8'b01_11_10_10; lsb_v = 12'o1001;
    for (int i = 0; i < 4; i++) begin
      sel64 = sel_v[i];
      bus_load(64'hA5A5_0000 + 64'(i));
      run_cmd(rd_v[i], wr_v[i], sz_v[2*i +: 2], 0, int'(lsb_v[3*i +: 3]), 64'h1234, 0, 0);
      checks++;
      if (obs_req !== 0 || obs_done_at !== 0 || obs_err !== 1'b1 || obs_mdr !== 64'hA5A5_0000 + 64'(i)) begin
        errors++; $display("FAIL illegal_%0d got req=%0d done_at=%0d err=%b mdr=%h exp 0/0/1/%h",
                           i, obs_req, obs_done_at, obs_err, obs_mdr, 64'hA5A5_0000 + 64'(i));
      end
    end
  endtask

  task automatic test_reg64;
    sel64 = 1'b1;
    run_cmd(1, 0, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 1, 0);
    checks++;
    if (obs_mdr !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL dword_read got %h exp 0123456789abcdef", obs_mdr); end
    run_cmd(1, 0, 2'b10, 0, 4, 64'h89AB_CDEF_0123_4567, 0, 0);
    checks++;
    if (obs_mdr !== 64'h0000_0000_89AB_CDEF) begin errors++; $display("FAIL uword_read64 got %h exp 0000000089abcdef", obs_mdr); end
    run_cmd(1, 0, 2'b10, 1, 4, 64'h89AB_CDEF_0123_4567, 0, 0);
    checks++;
    if (obs_mdr !== 64'hFFFF_FFFF_89AB_CDEF) begin errors++; $display("FAIL sword_read64 got %h exp ffffffff89abcdef", obs_mdr); end
    run_cmd(0, 1, 2'b11, 0, 0, 64'h0, 0, 0);
    checks++;
    if ({obs_be, obs_dout} !== {8'hFF, 64'hFFFF_FFFF_89AB_CDEF}) begin
      errors++; $display("FAIL dword_store got be=%h data=%h exp ff/ffffffff89abcdef", obs_be, obs_dout);
    end
  endtask

  task automatic test_back_to_back;
    sel64 = 1'b0;
    mem_read = 1'b1; sz = 2'b10; sext = 1'b0; lsb = 3'd0; mdata = 64'h1111_AAAA;
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0; mdata = 64'h2222_BBBB;
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", o_done); end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_mdr !== 64'h1111_AAAA) begin
      errors++; $display("FAIL b2b_not_queued got busy=%b mdr=%h exp 0/1111aaaa", o_busy, o_mdr);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL b2b_second_req got %b exp 1", o_req); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_mdr !== 64'h2222_BBBB) begin
      errors++; $display("FAIL b2b_second got done=%b mdr=%h exp 1/2222bbbb", o_done, o_mdr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [63:0] model_mdr [2];
    model_mdr[0] = o_mdr;
    sel64 = 1'b1; #1 model_mdr[1] = o_mdr;
    for (int n = 0; n < 60; n++) begin
      int w, l, r, k, exp_req, exp_done;
      bit rd, wr, legal, noise, exp_err;
      logic [1:0] s;
      logic [63:0] md, exp_mdr;
      sel64 = 1'($urandom % 2);
      w = sel64 ? 64 : 32;
      if ($urandom % 3 == 0) begin
        md = {$urandom, $urandom};
        bus_load(md);
        model_mdr[sel64] = md & wmask(w);
      end
      k = $urandom % 8;
      rd = (k == 0) || (k < 5); wr = (k == 0) || (k >= 5);
      s = 2'($urandom % 4);
      l = $urandom % (w / 8);
      if ($urandom % 4 != 0) l = l - (l % (1 << s));
      if (l >= w / 8) l = 0;
      r = ($urandom % 10 == 0) ? -1 : int'($urandom % 4);
      md = {$urandom, $urandom};
      noise = 1'($urandom % 2);
      legal = !(rd && wr) && ref_legal(s, l, w);
      exp_mdr = model_mdr[sel64];
      if (!legal) begin exp_req = 0; exp_done = 0; exp_err = 1'b1; end
      else if (r < 0) begin exp_req = 15; exp_done = 15; exp_err = 1'b1; end
      else begin
        exp_req = r + 1; exp_done = r + 1; exp_err = 1'b0;
        if (rd) exp_mdr = ref_load(md, s, sext, l, w);
      end
      sext = 1'($urandom % 2);
      if (legal && r >= 0 && rd) exp_mdr = ref_load(md, s, sext, l, w);
      run_cmd(rd, wr, s, sext, l, md, r, noise);
      checks++;
      if (obs_req !== exp_req || obs_done_at !== exp_done || obs_err !== exp_err || obs_after !== 2'b00) begin
        errors++; $display("FAIL rand%0d_ctrl got req=%0d done_at=%0d err=%b after=%b exp %0d/%0d/%b/00",
                           n, obs_req, obs_done_at, obs_err, obs_after, exp_req, exp_done, exp_err);
      end
      checks++;
      if (obs_mdr !== exp_mdr) begin errors++; $display("FAIL rand%0d_mdr got %h exp %h", n, obs_mdr, exp_mdr); end
      if (legal && wr) begin
        checks++;
        if ({obs_we, obs_be, obs_dout, obs_stable} !==
            {1'b1, ref_be(s, l), ref_store(model_mdr[sel64], s, l, w), 1'b1}) begin
          errors++; $display("FAIL rand%0d_store got we=%b be=%h data=%h stable=%b exp 1/%h/%h/1", n,
                             obs_we, obs_be, obs_dout, obs_stable, ref_be(s, l), ref_store(model_mdr[sel64], s, l, w));
        end
      end
      model_mdr[sel64] = exp_mdr;
    end
  endtask

  initial begin
    test_reset;
    test_bus_load;
    test_signed_byte;
    test_half_store;
    test_timeout;
    test_illegal;
    test_reg64;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
